// File: rtl/router_psum_load_if.sv
// Handshake bundle between the psum load router, the psum GLB read port,
// the PE psum spad load port and the cluster controller.
interface router_psum_load_if #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int X_dim             = 5
);
  logic                              load_psum_ctrl;
  logic                              iter_clr;
  logic [DATA_BITWIDTH-1:0]          r_data_glb_psum;
  logic [ADDR_BITWIDTH_GLB-1:0]      r_addr_glb_psum;
  logic                              read_en_glb_psum;
  logic [DATA_BITWIDTH*X_dim-1:0]    w_data_spad_psum;
  logic                              load_en_spad_psum;
  logic                              load_done;
  logic                              busy;

  modport master (
    input  load_psum_ctrl,
    input  iter_clr,
    input  r_data_glb_psum,
    output r_addr_glb_psum,
    output read_en_glb_psum,
    output w_data_spad_psum,
    output load_en_spad_psum,
    output load_done,
    output busy
  );

  modport slave (
    output load_psum_ctrl,
    output iter_clr,
    output r_data_glb_psum,
    input  r_addr_glb_psum,
    input  read_en_glb_psum,
    input  w_data_spad_psum,
    input  load_en_spad_psum,
    input  load_done,
    input  busy
  );
endinterface

// File: rtl/router_psum_load.sv
// Reads one row of X_dim partial sums from the psum GLB, packs them into a
// single lane word and strobes it into the PE-row psum scratchpads.
//
// state | meaning
// IDLE  | waiting for load_psum_ctrl; iter_clr honoured here only
// READ  | read_en high, one GLB address per cycle for X_dim cycles
// DRAIN | waiting for the last GLB read data to be captured
// LOAD  | load strobe high for one cycle, row index advances
module router_psum_load #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int X_dim             = 5,
  parameter int NUM_ROWS          = 3,
  parameter int PSUM_READ_ADDR    = 0
) (
  input  logic              clk,
  input  logic              reset,
  router_psum_load_if.master bus
);

  localparam int RD_W   = (X_dim > 1) ? $clog2(X_dim) : 1;
  localparam int CAP_W  = $clog2(X_dim + 1);
  localparam int ITER_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int PACK_W = DATA_BITWIDTH * X_dim;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    LOAD  = 2'd3
  } state_t;

  state_t                       state;
  logic [RD_W-1:0]              rd_cnt;
  logic [CAP_W-1:0]             cap_cnt;
  logic [ITER_W-1:0]            iter;
  logic                         read_en_d;
  logic [PACK_W-1:0]            pack;
  logic [PACK_W-1:0]            pack_next;
  logic [ITER_W-1:0]            iter_eff;
  logic [ADDR_BITWIDTH_GLB-1:0] base_addr;
  logic                         cap_done;

  logic [ADDR_BITWIDTH_GLB-1:0] r_addr;
  logic                         read_en;
  logic [PACK_W-1:0]            w_data;
  logic                         load_en;
  logic                         done;
  logic                         busy;

  assign bus.r_addr_glb_psum   = r_addr;
  assign bus.read_en_glb_psum  = read_en;
  assign bus.w_data_spad_psum  = w_data;
  assign bus.load_en_spad_psum = load_en;
  assign bus.load_done         = done;
  assign bus.busy              = busy;

  // A clear arriving with the start must already select row 0.
  assign iter_eff  = bus.iter_clr ? '0 : iter;
  assign base_addr = ADDR_BITWIDTH_GLB'(PSUM_READ_ADDR + int'(iter_eff) * X_dim);

  // Lane write for the current qualified cycle, merged combinationally so the
  // final lane can go straight out with the load strobe.
  always_comb begin
    pack_next = pack;
    for (int k = 0; k < X_dim; k++) begin
      if (read_en_d && cap_cnt == CAP_W'(k)) begin
        pack_next[k*DATA_BITWIDTH +: DATA_BITWIDTH] = bus.r_data_glb_psum;
      end
    end
  end

  assign cap_done = (cap_cnt == CAP_W'(X_dim)) ||
                    (read_en_d && cap_cnt == CAP_W'(X_dim - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      cap_cnt   <= '0;
      iter      <= '0;
      read_en_d <= 1'b0;
      pack      <= '0;
      r_addr    <= '0;
      read_en   <= 1'b0;
      w_data    <= '0;
      load_en   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      read_en_d <= read_en;
      pack      <= pack_next;
      if (read_en_d && cap_cnt != CAP_W'(X_dim)) begin
        cap_cnt <= cap_cnt + CAP_W'(1);
      end

      case (state)
        IDLE: begin
          read_en <= 1'b0;
          load_en <= 1'b0;
          done    <= 1'b0;
          if (bus.iter_clr) begin
            iter <= '0;
          end
          if (bus.load_psum_ctrl) begin
            state   <= READ;
            read_en <= 1'b1;
            r_addr  <= base_addr;
            rd_cnt  <= '0;
            cap_cnt <= '0;
            busy    <= 1'b1;
          end
        end

        READ: begin
          if (rd_cnt == RD_W'(X_dim - 1)) begin
            read_en <= 1'b0;
            state   <= DRAIN;
          end else begin
            r_addr <= r_addr + ADDR_BITWIDTH_GLB'(1);
            rd_cnt <= rd_cnt + RD_W'(1);
          end
        end

        DRAIN: begin
          if (cap_done) begin
            w_data  <= pack_next;
            load_en <= 1'b1;
            done    <= 1'b1;
            state   <= LOAD;
          end
        end

        LOAD: begin
          load_en <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          iter    <= (iter == ITER_W'(NUM_ROWS - 1)) ? '0 : iter + ITER_W'(1);
          state   <= IDLE;
        end

        default: begin
          state   <= IDLE;
          read_en <= 1'b0;
          load_en <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_psum_load.sv
// Directed bench for router_psum_load: a table of start/clear vectors with
// hand-computed base addresses, plus reset-abort, held-ctrl and wrap cases.
module tb_router_psum_load;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int XD = 5;
  localparam int NR = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [DW-1:0] glb_mem [0:(1<<AW)-1];

  router_psum_load_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .X_dim(XD)) bus ();
  router_psum_load_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .X_dim(XD)) wbus ();

  router_psum_load #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .X_dim(XD),
    .NUM_ROWS(NR), .PSUM_READ_ADDR(0)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  router_psum_load #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .X_dim(XD),
    .NUM_ROWS(NR), .PSUM_READ_ADDR(1022)
  ) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (wbus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read GLB models: data appears one cycle after read_en is sampled.
  always @(posedge clk) begin
    if (bus.read_en_glb_psum) bus.r_data_glb_psum <= glb_mem[bus.r_addr_glb_psum];
  end
  always @(posedge clk) begin
    if (wbus.read_en_glb_psum) wbus.r_data_glb_psum <= glb_mem[wbus.r_addr_glb_psum];
  end

  typedef struct {
    logic clr;
    int   exp_base;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW*XD-1:0] exp_pack(input int base);
    logic [DW*XD-1:0] p;
    p = '0;
    for (int k = 0; k < XD; k++) begin
      p[k*DW +: DW] = DW'(((base + k) % (1 << AW)) + 100);
    end
    return p;
  endfunction

  task automatic do_load(input logic clr, input int exp_base);
    int n;
    int rd_cycles;
    @(negedge clk);
    bus.load_psum_ctrl = 1'b1;
    bus.iter_clr       = clr;
    @(negedge clk);
    bus.load_psum_ctrl = 1'b0;
    bus.iter_clr       = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_addr", bus.r_addr_glb_psum, exp_base);
    n = 0;
    rd_cycles = 0;
    while (!bus.load_en_spad_psum && n < 12) begin
      if (bus.read_en_glb_psum) begin
        chk("rd_addr", bus.r_addr_glb_psum, (exp_base + rd_cycles) % (1 << AW));
        rd_cycles++;
      end
      chk("busy_run", bus.busy, 1);
      @(negedge clk);
      n++;
    end
    chk("load_seen", bus.load_en_spad_psum, 1);
    chk("load_latency", n, 6);
    chk("rd_cycles", rd_cycles, XD);
    chk("load_done", bus.load_done, 1);
    chk("busy_load", bus.busy, 1);
    chk("w_data", bus.w_data_spad_psum, exp_pack(exp_base));
    @(negedge clk);
    chk("strobe_drop", bus.load_en_spad_psum, 0);
    chk("done_drop", bus.load_done, 0);
    chk("busy_idle", bus.busy, 0);
    chk("w_data_hold", bus.w_data_spad_psum, exp_pack(exp_base));
  endtask

  initial begin
    int starts;
    int strobes;
    int bases [4];
    logic prev_rd;
    logic any_strobe;
    int n;
    int waddr [XD];
    int wcnt;

    checks = 0;
    errors = 0;
    for (int a = 0; a < (1 << AW); a++) glb_mem[a] = DW'(a + 100);

    // start/clear vectors with the base each load must use
    vecs[0] = '{1'b0, 0};
    vecs[1] = '{1'b0, 5};
    vecs[2] = '{1'b0, 10};
    vecs[3] = '{1'b0, 0};
    vecs[4] = '{1'b0, 5};
    vecs[5] = '{1'b1, 0};
    vecs[6] = '{1'b0, 5};

    reset = 1'b1;
    bus.load_psum_ctrl  = 1'b0;
    bus.iter_clr        = 1'b0;
    wbus.load_psum_ctrl = 1'b0;
    wbus.iter_clr       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_read_en", bus.read_en_glb_psum, 0);
    chk("rst_addr", bus.r_addr_glb_psum, 0);
    chk("rst_w_data", bus.w_data_spad_psum, 0);
    chk("rst_load_en", bus.load_en_spad_psum, 0);
    chk("rst_done", bus.load_done, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].clr, vecs[i].exp_base);
    end

    // reset while the third address is presented aborts the transfer
    @(negedge clk);
    bus.load_psum_ctrl = 1'b1;
    @(negedge clk);
    bus.load_psum_ctrl = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_addr", bus.r_addr_glb_psum, 12);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_read_en", bus.read_en_glb_psum, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_w_data", bus.w_data_spad_psum, 0);
    chk("abort_load_en", bus.load_en_spad_psum, 0);
    any_strobe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.load_en_spad_psum || bus.busy) any_strobe = 1'b1;
    end
    chk("abort_no_strobe", any_strobe, 0);
    do_load(1'b0, 0);

    // ctrl held for 20 cycles: restarts only from IDLE, one strobe each
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.load_psum_ctrl = 1'b1;
    starts = 0;
    strobes = 0;
    prev_rd = 1'b0;
    for (int i = 0; i < 4; i++) bases[i] = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.read_en_glb_psum && !prev_rd) begin
        if (starts < 4) bases[starts] = int'(bus.r_addr_glb_psum);
        starts++;
      end
      prev_rd = bus.read_en_glb_psum;
      if (bus.load_en_spad_psum) strobes++;
    end
    bus.load_psum_ctrl = 1'b0;
    chk("hold_strobes_window", strobes, 2);
    chk("hold_base0", bases[0], 0);
    chk("hold_base1", bases[1], 5);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.read_en_glb_psum && !prev_rd) begin
        if (starts < 4) bases[starts] = int'(bus.r_addr_glb_psum);
        starts++;
      end
      prev_rd = bus.read_en_glb_psum;
      if (bus.load_en_spad_psum) strobes++;
    end
    chk("hold_starts", starts, 3);
    chk("hold_base2", bases[2], 10);
    chk("hold_strobes_total", strobes, 3);
    chk("hold_idle", bus.busy, 0);

    // base near the top of the GLB: addresses wrap modulo 2^AW
    @(negedge clk);
    wbus.load_psum_ctrl = 1'b1;
    @(negedge clk);
    wbus.load_psum_ctrl = 1'b0;
    n = 0;
    wcnt = 0;
    while (!wbus.load_en_spad_psum && n < 12) begin
      if (wbus.read_en_glb_psum) begin
        if (wcnt < XD) waddr[wcnt] = int'(wbus.r_addr_glb_psum);
        wcnt++;
      end
      @(negedge clk);
      n++;
    end
    chk("wrap_load_seen", wbus.load_en_spad_psum, 1);
    chk("wrap_rd_cycles", wcnt, XD);
    chk("wrap_addr0", waddr[0], 1022);
    chk("wrap_addr1", waddr[1], 1023);
    chk("wrap_addr2", waddr[2], 0);
    chk("wrap_addr3", waddr[3], 1);
    chk("wrap_addr4", waddr[4], 2);
    chk("wrap_w_data", wbus.w_data_spad_psum, exp_pack(1022));
    chk("wrap_done", wbus.load_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_psum_load.md
Name: router_psum_load

Overview:
- Upstream companion of the psum write-back router. Reads X_dim partial sums one at a time from the psum GLB bank.
- Packs them into one X_dim-lane word and loads that word into the PE-row psum scratchpads, so the next pass can accumulate onto it.
- Sits between the psum GLB read port and the PE cluster psum spad load port. Driven by a start pulse from the cluster controller.

Parameters:
- DATA_BITWIDTH, 16, width of one psum.
- ADDR_BITWIDTH_GLB, 10, psum GLB address width.
- X_dim, 5, psums per row, i.e. number of output lanes.
- NUM_ROWS, 3, number of rows per layer; the row index wraps at this value.
- PSUM_READ_ADDR, 0, GLB base address of row 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- load_psum_ctrl  in  1  start request; sampled only in IDLE
- iter_clr  in  1  clears the row index to 0 (new layer); honoured only in IDLE
- r_data_glb_psum  in  DATA_BITWIDTH  GLB read data; valid one cycle after GLB samples read_en
- r_addr_glb_psum  out  ADDR_BITWIDTH_GLB  GLB read address (registered)
- read_en_glb_psum  out  1  GLB read enable (registered)
- w_data_spad_psum  out  DATA_BITWIDTH*X_dim  packed psums; lane k at bits [(k+1)*DATA_BITWIDTH-1 -: DATA_BITWIDTH]
- load_en_spad_psum  out  1  one-cycle load strobe to the PE spads
- load_done  out  1  one-cycle pulse, coincident with load_en_spad_psum
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - All outputs 0, including w_data_spad_psum and r_addr_glb_psum.
  - Internal counters and row index iter = 0.
  - Reset mid-operation aborts the transfer; no load strobe is produced.
- FSM states:
  - IDLE: if iter_clr, iter<=0. If load_psum_ctrl, go to READ, set read_en<=1 and r_addr<=PSUM_READ_ADDR + iter_eff*X_dim. iter_eff is 0 when iter_clr is also high that cycle, otherwise iter. Set rd_cnt<=0. Otherwise read_en<=0.
  - READ: read_en held high for exactly X_dim cycles; r_addr increments by 1 each cycle. After the edge presenting the last address (rd_cnt==X_dim-1), read_en<=0 and go to DRAIN.
  - Capture (runs through READ and DRAIN): a one-cycle delayed copy of read_en qualifies r_data_glb_psum. Each qualified cycle writes lane cap_cnt of an internal pack register, then cap_cnt increments. Lane 0 receives address base+0.
  - DRAIN: wait for the final capture (cap_cnt reaches X_dim). Then w_data_spad_psum<=pack register, load_en_spad_psum<=1, load_done<=1, go to LOAD.
  - LOAD: strobes drop to 0 next edge. iter<=iter+1, wrapping to 0 after NUM_ROWS-1. Go to IDLE.
- Latency:
  - load_psum_ctrl sampled at edge E0 → read_en high from E0 to E0+X_dim.
  - load_en_spad_psum high for the one cycle after edge E0+X_dim+1.
  - Next start is accepted two edges later, from IDLE.
- w_data_spad_psum holds its value after the strobe until the next load. Consumers sample it only on load_en_spad_psum.
- Address arithmetic is modulo 2^ADDR_BITWIDTH_GLB; overflow wraps silently.
- load_psum_ctrl and iter_clr are ignored while busy=1, including a ctrl asserted in the same cycle as the load strobe. No queuing.
- GLB read data is never sampled outside qualified cycles; lanes are written in ascending order only.

Test Plan:
- Defaults; GLB rows 0..14 preloaded with value = addr+100; pulse ctrl → read_en for 5 cycles at addr 0..4; load_en after 6 cycles; lanes 0..4 = 100..104; load_done coincident; busy high throughout.
- Three back-to-back starts, each issued once busy drops → base addresses 0, 5, 10. A fourth start → base 0 (iter wraps at NUM_ROWS=3).
- After two loads, assert iter_clr together with ctrl → base address 0, iter advances to 1.
- Hold ctrl high continuously for 20 cycles → loads at bases 0 and 5, exactly one strobe per transfer. Ctrl during READ/DRAIN/LOAD is ignored.
- Assert reset during READ (third address) → next edge: read_en=0, busy=0, w_data=0, no load_en. A subsequent start reads base 0.
- PSUM_READ_ADDR=1022, X_dim=5 → addresses 1022, 1023, 0, 1, 2; lanes match the wrapped GLB contents.
